// File: rtl/note_scroller.sv
// Two-lane chart sequencer: streams 32-bit note words from the chart ROM and
// advances a shared scroll index once per beat, with a one-word prefetch buffer.
module note_scroller #(
  parameter int SONG_WORDS = 16,
  parameter int BEAT_DIV   = 1000000,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [2:0]        mode,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_valid,
  input  logic [31:0]       rom_data1,
  input  logic [31:0]       rom_data2,
  output logic [31:0]       next_note1,
  output logic [31:0]       next_note2,
  output logic [4:0]        next_idx1,
  output logic [4:0]        next_idx2,
  output logic              song_done,
  output logic              underrun
);

  localparam int CNT_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BEAT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] WORD_LAST = PTR_W'(SONG_WORDS - 1);
  localparam logic [PTR_W-1:0] WORD_END  = PTR_W'(SONG_WORDS);
  localparam logic [2:0]       MODE_PLAY = 3'd2;

  typedef enum logic [1:0] {IDLE, LOAD0, PLAY, DONE} state_t;

  state_t            state_q;
  logic [31:0]       note1_q, note2_q;
  logic [31:0]       pf1_q, pf2_q;
  logic [4:0]        idx_q;
  logic [PTR_W-1:0]  word_ptr_q, fetch_ptr_q;
  logic              pf_valid_q;
  logic              pend_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q, unr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic play, tick, boundary, fetch_go, pf_load;

  always_comb begin
    play     = (mode == MODE_PLAY);
    tick     = (cnt_q == CNT_LAST);
    cnt_d    = tick ? '0 : cnt_q + CNT_ONE;
    boundary = (idx_q == 5'd31);
    // pend_q guarantees at most one request in flight; a stray rom_valid is dropped
    fetch_go = !pf_valid_q && !pend_q && (fetch_ptr_q < WORD_END);
    pf_load  = play && (state_q == PLAY) && rom_valid && pend_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      note1_q     <= '0;
      note2_q     <= '0;
      idx_q       <= '0;
      word_ptr_q  <= '0;
      fetch_ptr_q <= '0;
      pf_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      unr_q       <= 1'b0;
      cnt_q       <= '0;
    end else if (!play) begin
      state_q     <= IDLE;
      note1_q     <= '0;
      note2_q     <= '0;
      idx_q       <= '0;
      word_ptr_q  <= '0;
      fetch_ptr_q <= '0;
      pf_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      unr_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= LOAD0;
          rd_q    <= 1'b1;
          addr_q  <= '0;
          pend_q  <= 1'b1;
        end
        LOAD0: begin
          if (rom_valid && pend_q) begin
            note1_q     <= rom_data1;
            note2_q     <= rom_data2;
            idx_q       <= '0;
            word_ptr_q  <= '0;
            fetch_ptr_q <= PTR_ONE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            state_q     <= PLAY;
          end
        end
        PLAY: begin
          cnt_q <= cnt_d;
          if (fetch_go) begin
            rd_q   <= 1'b1;
            addr_q <= fetch_ptr_q[ADDR_W-1:0];
            pend_q <= 1'b1;
          end
          if (pf_load) begin
            pf_valid_q  <= 1'b1;
            fetch_ptr_q <= fetch_ptr_q + PTR_ONE;
            pend_q      <= 1'b0;
          end
          // The tick looks at the old pf_valid_q, so a word arriving on a stalled
          // boundary tick is only consumed on the following tick.
          if (tick) begin
            if (!boundary) begin
              idx_q <= idx_q + 5'd1;
            end else if (word_ptr_q == WORD_LAST) begin
              state_q <= DONE;
              note1_q <= '0;
              note2_q <= '0;
              idx_q   <= '0;
              done_q  <= 1'b1;
            end else if (pf_valid_q) begin
              note1_q    <= pf1_q;
              note2_q    <= pf2_q;
              idx_q      <= '0;
              word_ptr_q <= word_ptr_q + PTR_ONE;
              pf_valid_q <= 1'b0;
            end else begin
              unr_q <= 1'b1;
            end
          end
        end
        DONE: begin
          note1_q <= '0;
          note2_q <= '0;
          idx_q   <= '0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pf_load) begin
      pf1_q <= rom_data1;
      pf2_q <= rom_data2;
    end
  end

  assign rom_rd     = rd_q;
  assign rom_addr   = addr_q;
  assign next_note1 = note1_q;
  assign next_note2 = note2_q;
  assign next_idx1  = idx_q;
  assign next_idx2  = idx_q;
  assign song_done  = done_q;
  assign underrun   = unr_q;

endmodule

// File: tb/tb_note_scroller.sv
// Scoreboard bench for note_scroller: a 3-word song instance and a 1-word song
// instance, each with a fixed-latency ROM responder.
module tb_note_scroller;

  logic        clk  = 1'b0;
  logic        nrst = 1'b1;
  logic [2:0]  mode      [2];
  logic        rom_rd    [2];
  logic [3:0]  rom_addr  [2];
  logic        rom_valid [2] = '{1'b0, 1'b0};
  logic [31:0] rom_data1 [2] = '{32'h0, 32'h0};
  logic [31:0] rom_data2 [2] = '{32'h0, 32'h0};
  logic [31:0] nn1 [2];
  logic [31:0] nn2 [2];
  logic [4:0]  ni1 [2];
  logic [4:0]  ni2 [2];
  logic        sd  [2];
  logic        ur  [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  note_scroller #(.SONG_WORDS(3), .BEAT_DIV(4), .ADDR_W(4)) dut0 (
    .clk(clk), .nrst(nrst), .mode(mode[0]),
    .rom_rd(rom_rd[0]), .rom_addr(rom_addr[0]), .rom_valid(rom_valid[0]),
    .rom_data1(rom_data1[0]), .rom_data2(rom_data2[0]),
    .next_note1(nn1[0]), .next_note2(nn2[0]), .next_idx1(ni1[0]), .next_idx2(ni2[0]),
    .song_done(sd[0]), .underrun(ur[0]));

  note_scroller #(.SONG_WORDS(1), .BEAT_DIV(4), .ADDR_W(4)) dut1 (
    .clk(clk), .nrst(nrst), .mode(mode[1]),
    .rom_rd(rom_rd[1]), .rom_addr(rom_addr[1]), .rom_valid(rom_valid[1]),
    .rom_data1(rom_data1[1]), .rom_data2(rom_data2[1]),
    .next_note1(nn1[1]), .next_note2(nn2[1]), .next_idx1(ni1[1]), .next_idx2(ni2[1]),
    .song_done(sd[1]), .underrun(ur[1]));

  localparam logic [31:0] WA1 = 32'hA0000001, WB1 = 32'hB0000002, WC1 = 32'hC0000003;
  localparam logic [31:0] WA2 = 32'h5A5A0001, WB2 = 32'h5A5A0002, WC2 = 32'h5A5A0003;
  logic [31:0] w1 [4] = '{WA1, WB1, WC1, 32'h0};
  logic [31:0] w2 [4] = '{WA2, WB2, WC2, 32'h0};

  // ROM responder: one request at a time, data presented lat[u] cycles later
  int         lat   [2] = '{2, 2};
  int         rcnt  [2] = '{0, 0};
  logic [1:0] raddr [2] = '{2'd0, 2'd0};
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      rom_valid[u] = 1'b0;
      if (rcnt[u] > 0) begin
        rcnt[u] = rcnt[u] - 1;
        if (rcnt[u] == 0) begin
          rom_valid[u] = 1'b1;
          rom_data1[u] = w1[raddr[u]];
          rom_data2[u] = w2[raddr[u]];
        end
      end
      if (rom_rd[u] === 1'b1) begin
        rcnt[u]  = lat[u];
        raddr[u] = rom_addr[u][1:0];
      end
    end
  end

  typedef struct {
    logic [31:0] n1, n2;
    logic [4:0]  idx;
    logic        done, unr;
    int          dmin, dmax, acyc;
  } disp_t;
  typedef struct {
    logic [3:0] addr;
    int         acyc;
  } addr_t;
  typedef struct {
    logic [31:0] n1, n2;
    logic [4:0]  idx;
    logic        done, unr, rd;
    logic [3:0]  addr;
    bit          chk_addr;
  } probe_t;

  disp_t  dq0[$], dq1[$];
  addr_t  aq0[$], aq1[$];
  probe_t pq0[$];

  int checks = 0;
  int failures = 0;
  bit fin_req = 1'b0;
  bit fin_ack = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [74:0] prev     [2] = '{75'd0, 75'd0};
  int          last_evt [2] = '{0, 0};

  task automatic mon(input int u);
    logic [74:0] cur;
    disp_t  e;
    addr_t  a;
    probe_t p;
    int     d;
    cur = {nn1[u], nn2[u], ni1[u], ni2[u], sd[u]};
    if (rom_rd[u] === 1'b1) begin
      if ((u == 0 && aq0.size() == 0) || (u == 1 && aq1.size() == 0)) begin
        checks++; failures++;
        $display("FAIL rom_rd_unexpected u%0d: got addr %0h, expected no request", u, rom_addr[u]);
      end else begin
        a = (u == 0) ? aq0.pop_front() : aq1.pop_front();
        cmp($sformatf("rom_addr u%0d", u), 64'(rom_addr[u]), 64'(a.addr));
        if (a.acyc >= 0) cmp($sformatf("rom_rd_cycle u%0d", u), 64'(cyc), 64'(a.acyc));
      end
    end
    if (cur !== prev[u]) begin
      if ((u == 0 && dq0.size() == 0) || (u == 1 && dq1.size() == 0)) begin
        checks++; failures++;
        $display("FAIL display_unexpected u%0d: got note1=%0h idx=%0d done=%0b, expected no change",
                 u, nn1[u], ni1[u], sd[u]);
      end else begin
        e = (u == 0) ? dq0.pop_front() : dq1.pop_front();
        cmp($sformatf("note1 u%0d", u), 64'(nn1[u]), 64'(e.n1));
        cmp($sformatf("note2 u%0d", u), 64'(nn2[u]), 64'(e.n2));
        cmp($sformatf("idx1 u%0d", u), 64'(ni1[u]), 64'(e.idx));
        cmp($sformatf("idx2 u%0d", u), 64'(ni2[u]), 64'(e.idx));
        cmp($sformatf("song_done u%0d", u), 64'(sd[u]), 64'(e.done));
        cmp($sformatf("underrun u%0d", u), 64'(ur[u]), 64'(e.unr));
        if (e.acyc >= 0) cmp($sformatf("event_cycle u%0d", u), 64'(cyc), 64'(e.acyc));
        if (e.dmin >= 0) begin
          d = cyc - last_evt[u];
          checks++;
          if (d < e.dmin || d > e.dmax) begin
            failures++;
            $display("FAIL step_interval u%0d: got %0d cycles, expected %0d..%0d", u, d, e.dmin, e.dmax);
          end
        end
      end
      prev[u]     = cur;
      last_evt[u] = cyc;
    end
    if (u == 0) begin
      while (pq0.size() > 0) begin
        p = pq0.pop_front();
        cmp("probe note1", 64'(nn1[0]), 64'(p.n1));
        cmp("probe note2", 64'(nn2[0]), 64'(p.n2));
        cmp("probe idx1", 64'(ni1[0]), 64'(p.idx));
        cmp("probe idx2", 64'(ni2[0]), 64'(p.idx));
        cmp("probe song_done", 64'(sd[0]), 64'(p.done));
        cmp("probe underrun", 64'(ur[0]), 64'(p.unr));
        cmp("probe rom_rd", 64'(rom_rd[0]), 64'(p.rd));
        if (p.chk_addr) cmp("probe rom_addr", 64'(rom_addr[0]), 64'(p.addr));
      end
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) mon(u);
    if (fin_req && !fin_ack) begin
      cmp("addr_left u0", 64'(aq0.size()), 64'd0);
      cmp("addr_left u1", 64'(aq1.size()), 64'd0);
      cmp("disp_left u0", 64'(dq0.size()), 64'd0);
      cmp("disp_left u1", 64'(dq1.size()), 64'd0);
      fin_ack = 1'b1;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string nm);
    $display("FAIL timeout %s: got no event, expected one within bound", nm);
    $fatal(1, "bench stopped on timeout");
  endtask

  task automatic pd(input int u, input logic [31:0] n1, input logic [31:0] n2, input logic [4:0] idx,
                    input logic done, input logic unr, input int dmin, input int dmax, input int acyc);
    disp_t e;
    e.n1 = n1; e.n2 = n2; e.idx = idx; e.done = done; e.unr = unr;
    e.dmin = dmin; e.dmax = dmax; e.acyc = acyc;
    if (u == 0) dq0.push_back(e); else dq1.push_back(e);
  endtask

  task automatic pa(input int u, input logic [3:0] addr, input int acyc);
    addr_t a;
    a.addr = addr; a.acyc = acyc;
    if (u == 0) aq0.push_back(a); else aq1.push_back(a);
  endtask

  task automatic pp(input logic [31:0] n1, input logic [31:0] n2, input logic [4:0] idx, input logic done,
                    input logic unr, input logic rd, input logic [3:0] addr, input bit chk_addr);
    probe_t p;
    p.n1 = n1; p.n2 = n2; p.idx = idx; p.done = done; p.unr = unr;
    p.rd = rd; p.addr = addr; p.chk_addr = chk_addr;
    pq0.push_back(p);
  endtask

  // Index steps 1..last of one word, one beat (4 cycles) apart
  task automatic run_word(input int u, input logic [31:0] n1, input logic [31:0] n2, input logic unr,
                          input int last);
    for (int i = 1; i <= last; i++) pd(u, n1, n2, 5'(i), 1'b0, unr, 4, 4, -1);
  endtask

  initial begin
    int k;
    mode[0] = 3'd0;
    mode[1] = 3'd0;
    #2 nrst = 1'b0;
    step(2);
    pp(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    step(1);
    nrst = 1'b1;
    step(2);

    // full 3-word song, ROM latency 2
    mode[0] = 3'd2;
    pa(0, 4'd0, cyc + 1);
    pa(0, 4'd1, -1);
    pa(0, 4'd2, -1);
    pd(0, WA1, WA2, 5'd0, 1'b0, 1'b0, -1, 0, -1);
    run_word(0, WA1, WA2, 1'b0, 31);
    pd(0, WB1, WB2, 5'd0, 1'b0, 1'b0, 4, 4, -1);
    run_word(0, WB1, WB2, 1'b0, 31);
    pd(0, WC1, WC2, 5'd0, 1'b0, 1'b0, 4, 4, -1);
    run_word(0, WC1, WC2, 1'b0, 31);
    pd(0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 4, 4, -1);
    k = 0;
    while (sd[0] !== 1'b1 && k < 600) begin step(); k++; end
    if (sd[0] !== 1'b1) timeout("song_done u0");
    step(5);
    pp(32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1);

    // leave play from DONE
    mode[0] = 3'd0;
    pd(0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, -1, 0, cyc + 1);
    step(3);
    pp(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    step(1);

    // asynchronous reset in the middle of play
    mode[0] = 3'd2;
    pa(0, 4'd0, cyc + 1);
    pa(0, 4'd1, -1);
    pd(0, WA1, WA2, 5'd0, 1'b0, 1'b0, -1, 0, -1);
    run_word(0, WA1, WA2, 1'b0, 5);
    k = 0;
    while (ni1[0] !== 5'd5 && k < 200) begin step(); k++; end
    if (ni1[0] !== 5'd5) timeout("idx5 u0");
    step(1);
    nrst = 1'b0;
    pd(0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, -1, 0, cyc);
    pp(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    step(2);

    // restart with slow ROM: first boundary stalls and flags underrun
    lat[0] = 200;
    nrst = 1'b1;
    pa(0, 4'd0, cyc + 1);
    pa(0, 4'd1, -1);
    pa(0, 4'd2, -1);
    pd(0, WA1, WA2, 5'd0, 1'b0, 1'b0, -1, 0, -1);
    run_word(0, WA1, WA2, 1'b0, 31);
    pd(0, WB1, WB2, 5'd0, 1'b0, 1'b1, 8, 2000, -1);
    run_word(0, WB1, WB2, 1'b1, 2);
    k = 0;
    while (nn1[0] !== WB1 && k < 2000) begin step(); k++; end
    if (nn1[0] !== WB1) timeout("word_b u0");
    step(10);
    // drop play while the word-2 request is still in flight
    mode[0] = 3'd0;
    pd(0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, -1, 0, cyc + 1);
    step(300);
    pp(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    step(1);

    // single-word song: no prefetch, done after 32 ticks
    mode[1] = 3'd2;
    pa(1, 4'd0, cyc + 1);
    pd(1, WA1, WA2, 5'd0, 1'b0, 1'b0, -1, 0, -1);
    run_word(1, WA1, WA2, 1'b0, 31);
    pd(1, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 4, 4, -1);
    k = 0;
    while (sd[1] !== 1'b1 && k < 400) begin step(); k++; end
    if (sd[1] !== 1'b1) timeout("song_done u1");
    step(5);

    fin_req = 1'b1;
    k = 0;
    while (!fin_ack && k < 5) begin step(); k++; end
    if (!fin_ack) timeout("final_check");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_scroller.md
# note_scroller

Chart sequencer feeding the two-lane note LED display stage. While the game is in play mode (mode = 2) it streams two lanes of 32-bit note words from the chart ROM and advances a shared scroll index once per beat. It presents the current word and bit index per lane (next_note1/2, next_idx1/2) to the display stage. A one-word prefetch buffer hides ROM latency across word boundaries.

## Interface
- SONG_WORDS, 16: number of 32-bit chart words per lane; must be ≥1.
- BEAT_DIV, 1000000: clk cycles per scroll step; must be ≥2.
- ADDR_W, 4: ROM address width; must satisfy 2^ADDR_W ≥ SONG_WORDS.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- nrst  in  1  reset, asynchronous, active-low.
- mode  in  3  game mode; the value 2 means play.
- rom_rd  out  1  single-cycle read request.
- rom_addr  out  ADDR_W  word address; valid while rom_rd = 1.
- rom_valid  in  1  read data valid; occurs ≥1 cycle after rom_rd, exactly once per request.
- rom_data1, rom_data2  in  32  lane 1 and lane 2 words; sampled when rom_valid = 1.
- next_note1, next_note2  out  32  current chart word per lane (registered).
- next_idx1, next_idx2  out  5  scroll index; both lanes always carry the same value.
- song_done  out  1  high after the last bit of the last word has been scrolled.
- underrun  out  1  sticky; set when a word boundary is reached without a prefetched word.

## Operation
- States: IDLE, LOAD0, PLAY, DONE.
- **IDLE**
  - Notes, indices, song_done, underrun, word_ptr, fetch_ptr and pf_valid are all 0.
  - mode = 2 → LOAD0.
- **LOAD0**
  - rom_rd = 1 for the first cycle only, with addr 0; then wait for rom_valid.
  - On rom_valid: note1/2 ← data, idx ← 0, word_ptr ← 0, fetch_ptr ← 1, beat counter ← 0 → PLAY.
- **PLAY, beat counter**
  - Counts 0..BEAT_DIV-1.
  - tick = 1 in the cycle where the counter equals BEAT_DIV-1; the counter then wraps to 0.
- **PLAY, fetch engine**
  - Issue one rom_rd (addr = fetch_ptr) when pf_valid = 0, no request is outstanding, and fetch_ptr < SONG_WORDS.
  - On rom_valid: pf1/pf2 ← data, pf_valid ← 1, fetch_ptr++.
  - rom_valid with no request outstanding is ignored.
- **PLAY, on tick**
  - idx < 31: idx++.
  - idx = 31 and word_ptr = SONG_WORDS-1: → DONE.
  - idx = 31 and pf_valid = 1: notes ← pf, idx ← 0, word_ptr++, pf_valid ← 0.
  - idx = 31 and pf_valid = 0: hold idx = 31 and notes, set underrun. Retry on the next tick; the beat counter keeps running.
- **Simultaneous rom_valid and a boundary tick with pf_valid = 0:** the tick sees the old pf_valid (stalls, sets underrun). The data is captured into pf and used on the next tick.
- **DONE**
  - notes = 0, idx = 0, song_done = 1, rom_rd = 0.
  - Stays in DONE while mode = 2.
- **Leaving play:** mode ≠ 2 in any state → IDLE on the next edge, clearing all state and outputs including underrun.
  - An outstanding ROM response that arrives later is ignored.
  - Re-entering mode 2 restarts the song at word 0.

## Timing
- Reset values: next_note1/2 = 0, next_idx1/2 = 0, rom_rd = 0, rom_addr = 0, song_done = 0, underrun = 0.
- All outputs are registered.
- mode becomes 2 at edge N → state LOAD0 and rom_rd = 1 after edge N+1.
- rom_valid sampled at edge M → notes and idx = 0 visible after edge M, state PLAY.
- First idx increment occurs BEAT_DIV cycles after PLAY entry.
- Steady state: one index step per BEAT_DIV cycles.
- Word swap happens in the same cycle as the idx 31→0 transition.
- Prefetch request issues one cycle after pf_valid clears (or after PLAY entry).
- Underrun-free operation requires ROM latency < 32·BEAT_DIV − 2.
- song_done rises one cycle after the final tick.

## Test plan
- Reset mid-PLAY (nrst low asynchronously) → all outputs 0 immediately; after release with mode = 2, LOAD0 restarts at addr 0.
- BEAT_DIV=4, SONG_WORDS=3, ROM latency 2, words lane1 = 0xA0000001/0xB0000002/0xC0000003 → rom_rd at addr 0, 1, 2, each exactly once.
  - Same setup: idx steps every 4 cycles; at 31→0 next_note1 changes to the next word in the same cycle.
  - Same setup: after 96 steps song_done = 1, notes = 0, underrun = 0.
- ROM latency 200 with BEAT_DIV=4 → at the first boundary idx holds at 31 and underrun = 1.
  - When data arrives, the next tick swaps the word with idx = 0; underrun stays 1.
- mode drops to 0 while a request is outstanding → IDLE next cycle, outputs 0.
  - A late rom_valid does not change next_note.
- SONG_WORDS=1 → no prefetch rom_rd is ever issued; DONE after 32 ticks.
